// File: rtl/uart_tx_rr_scheduler.sv
// Round-robin scheduler sharing one baud-paced UART transmitter among NUM_REQ byte producers.
// Optional launch-to-done watchdog is compiled in when UART_SCHED_WDOG_EN is defined.
module uart_tx_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_start,
    output logic [DATA_W-1:0]             uart_data,
    input  logic                          uart_busy,
    input  logic                          uart_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          err_timeout
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] scan_idx;
    logic            win_found;
    logic            grant;
    logic            timeout;

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    // srst suppresses the accept pulse so no byte is consumed and then lost.
    assign grant = (state == IDLE) && win_found && !srst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A done pulse while still launching means a short frame already finished.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (uart_done || timeout) begin
                    state_next = IDLE;
                end else if (uart_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (uart_done || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            uart_data <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            uart_data <= req_data[int'(win_id)*DATA_W +: DATA_W];
            grant_id  <= win_id;
            rr_ptr    <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    assign uart_start = (state == LAUNCH);
    assign active     = (state != IDLE);

`ifdef UART_SCHED_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] wdog_cnt;
    logic             err_flag;

    // Fires on the WDOG_CYCLES-th cycle after launch unless done arrives that cycle.
    assign timeout = (state != IDLE) && !uart_done &&
                     (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            wdog_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (grant) begin
                wdog_cnt <= '0;
            end else if (state != IDLE) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (timeout) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign err_timeout = err_flag;
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
